inverter_bank: RTL and testbench
================================

Name: inverter_bank

Overview:
- Parametrised, registered, multi-bit successor to the single-bit inverter.
- Each sample is a WIDTH-bit word. The block either passes it through, inverts every bit, or inverts only the bits selected by a programmable mask.
- It also has a toggle (T-flip-flop bank) mode.
- Fixed two-stage pipeline with a valid qualifier. Sits between the input conditioning logic and downstream consumers in the lab datapath.

Parameters:
- WIDTH, 8, number of bits per sample and per mask.
- INIT_MASK, {WIDTH{1'b1}}, value loaded into the mask register at reset. All-ones makes mode 2'b10 behave as a plain inverter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  input sample.
- din_valid  input  1  din is captured on this edge when high.
- mode  input  2  per-sample mode, captured together with din: 00 bypass, 01 invert all, 10 masked invert, 11 toggle.
- mask_in  input  WIDTH  new mask value.
- mask_load  input  1  mask_q <= mask_in on this edge when high.
- tog_clr  input  1  clears the toggle state register on this edge when high.
- dout  output  WIDTH  registered result.
- dout_valid  output  1  high for one cycle per result.
- mask_q  output  WIDTH  current mask register contents.
- tog_q  output  WIDTH  current toggle state register contents.

Behaviour:
- Reset (rst_n low, asynchronous): d1, m1, v1, dout, dout_valid and tog_q go to 0; mask_q goes to INIT_MASK. Outputs hold these values until the first rising edge after rst_n deasserts.
- Reset mid-operation discards any sample in flight; no dout_valid follows for it.
- Stage 1, each edge: v1 <= din_valid. When din_valid is high, d1 <= din and m1 <= mode; otherwise d1 and m1 hold.
- Stage 2, each edge with v1 high: dout <= f(d1, m1) and dout_valid <= 1. With v1 low: dout_valid <= 0 and dout holds its last value.
- f(d, m) by mode:
  - 00 → d.
  - 01 → ~d.
  - 10 → d ^ mask_q.
  - 11 → tog_q ^ (d & mask_q).
- Latency: din_valid high at edge N gives dout_valid high at edge N+1 (visible after edge N+1), i.e. 2 register stages. Throughput is one sample per cycle; back-to-back valids produce back-to-back results.
- Mask timing: stage 2 uses the pre-edge value of mask_q. A mask_load on the same edge as a stage-2 compute does not affect that sample; it applies from the next compute onward. mask_in is ignored when mask_load is low.
- Toggle state:
  - On an edge with v1 high and m1 = 11: tog_q <= tog_q ^ (d1 & mask_q), and dout equals the new tog_q.
  - Non-toggle samples leave tog_q unchanged.
  - tog_clr alone: tog_q <= 0.
  - tog_clr together with a toggle compute: clear first, then apply. tog_q <= d1 & mask_q and dout <= d1 & mask_q.
- mode is sampled per word, so mixed-mode back-to-back streams are legal and each word uses its own captured mode.
- All arithmetic is bitwise and WIDTH bits wide; there is no carry and no overflow.

Test Plan:
- Reset/defaults (WIDTH=8): hold rst_n low, then release → dout=0x00, dout_valid=0, tog_q=0x00, mask_q=0xFF. Then din=0x5A, mode=10, valid for one cycle → one cycle later dout=0xA5 with dout_valid=1 for exactly one cycle.
- Modes back-to-back: din 0x3C/00, 0x3C/01, 0x3C/10 with mask 0x0F, on consecutive cycles → dout 0x3C, 0xC3, 0x33 on consecutive cycles; dout_valid high for 3 cycles.
- Mask boundary: mask_load with 0xF0 on the same edge that a mode-10 sample din=0x00 computes → dout=0xFF (old mask). The next sample din=0x00 gives 0xF0.
- Toggle plus clear: mask=0xFF, mode 11, samples 0x01, 0x03, 0x01 → dout 0x01, 0x02, 0x03. Then tog_clr coincident with sample 0x80 → dout=0x80, tog_q=0x80.
- Gaps/hold: din_valid pulses separated by 3 idle cycles → dout_valid low during gaps, dout holds the last value, tog_q unchanged.
- Async reset mid-stream: assert rst_n between clock edges while v1=1 → outputs clear immediately, mask_q=0xFF, and no dout_valid appears after release.

Source files
------------

// File: rtl/inverter_bank.sv
// Registered WIDTH-bit inverter bank: bypass, invert-all, masked-invert and toggle modes
// through a fixed two-stage pipeline with a valid qualifier.
module inverter_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             mask_load,
  input  logic             tog_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] mask_q,
  output logic [WIDTH-1:0] tog_q
);

  // Valid-only stream, no backpressure: a word is accepted on every rising edge
  // where din_valid is high, and dout/dout_valid present its result exactly one
  // edge later for one cycle; dout holds its last value while dout_valid is low.

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_INV    = 2'b01;
  localparam logic [1:0] MODE_MASK   = 2'b10;
  localparam logic [1:0] MODE_TOG    = 2'b11;

  logic [WIDTH-1:0] d1;
  logic [1:0]       m1;
  logic             v1;

  logic [WIDTH-1:0] tog_base;
  logic [WIDTH-1:0] tog_next;
  logic [WIDTH-1:0] result;
  logic             tog_compute;

  // A coincident clear wipes the toggle state before the new sample is folded in.
  always_comb begin
    tog_base    = tog_clr ? '0 : tog_q;
    tog_next    = tog_base ^ (d1 & mask_q);
    tog_compute = v1 && (m1 == MODE_TOG);
    result      = d1;
    case (m1)
      MODE_BYPASS: result = d1;
      MODE_INV:    result = ~d1;
      MODE_MASK:   result = d1 ^ mask_q;
      MODE_TOG:    result = tog_next;
      default:     result = d1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
      m1 <= MODE_BYPASS;
    end else begin
      v1 <= din_valid;
      if (din_valid) begin
        d1 <= din;
        m1 <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= v1;
      if (v1) begin
        dout <= result;
      end
    end
  end

  // Stage 2 reads the pre-edge mask, so a load only affects later samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= INIT_MASK;
    end else if (mask_load) begin
      mask_q <= mask_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= '0;
    end else if (tog_compute) begin
      tog_q <= tog_next;
    end else if (tog_clr) begin
      tog_q <= '0;
    end
  end

endmodule

// File: tb/tb_inverter_bank.sv
// Bench for inverter_bank: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based behavioural model.
module tb_inverter_bank;

  localparam int W = 8;
  localparam logic [W-1:0] INIT_MASK = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] mask_in = '0;
  logic         mask_load = 1'b0;
  logic         tog_clr = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic [W-1:0] mask_q;
  logic [W-1:0] tog_q;

  int n_vec  = 0;
  int n_fail = 0;

  inverter_bank #(.WIDTH(W), .INIT_MASK(INIT_MASK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .mode       (mode),
    .mask_in    (mask_in),
    .mask_load  (mask_load),
    .tog_clr    (tog_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .mask_q     (mask_q),
    .tog_q      (tog_q)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]   m_mask;
  logic [W-1:0]   m_tog;
  logic [W-1:0]   m_dout;
  logic           m_valid;
  logic [W+1:0]   exp_q[$];  // in-flight words, {mode, data}

  function automatic logic [W-1:0] spec_f(input logic [W-1:0] d, input logic [1:0] md,
                                          input logic [W-1:0] mask, input logic [W-1:0] tog);
    case (md)
      2'b00:   return d;
      2'b01:   return ~d;
      2'b10:   return d ^ mask;
      default: return tog ^ (d & mask);
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_mask  = INIT_MASK;
    m_tog   = '0;
    m_dout  = '0;
    m_valid = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_dout"},       dout,             m_dout);
    check({tag, "_dout_valid"}, W'(dout_valid),   W'(m_valid));
    check({tag, "_tog_q"},      tog_q,            m_tog);
    check({tag, "_mask_q"},     mask_q,           m_mask);
  endtask

  initial begin : compare_proc
    logic [W+1:0] s;
    logic [W-1:0] base;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        #1;
        if (rst_n === 1'b0) compare_all("model_rst");
      end else begin
        m_valid = 1'b0;
        base    = tog_clr ? '0 : m_tog;
        m_tog   = base;
        if (exp_q.size() > 0) begin
          s       = exp_q.pop_front();
          m_valid = 1'b1;
          m_dout  = spec_f(s[W-1:0], s[W+1:W], m_mask, base);
          if (s[W+1:W] == 2'b11) m_tog = m_dout;
        end
        if (mask_load) m_mask = mask_in;
        if (din_valid) exp_q.push_back({mode, din});
        #1;
        compare_all("model");
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] md,
                      input logic ld, input logic [W-1:0] mi, input logic clr);
    din_valid = v;
    din       = d;
    mode      = md;
    mask_load = ld;
    mask_in   = mi;
    tog_clr   = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 2'b00, 1'b0, '0, 1'b0);
  endtask

  task automatic async_reset_pulse();
    din_valid = 1'b0;
    mask_load = 1'b0;
    tog_clr   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_dout",   dout,           8'h00);
    check("rst_valid",  W'(dout_valid), 8'h00);
    check("rst_tog",    tog_q,          8'h00);
    check("rst_mask",   mask_q,         8'hFF);

    // Default mask makes masked mode a plain inverter
    step(1'b1, 8'h5A, 2'b10, 1'b0, '0, 1'b0);
    idle();
    check("first_dout",  dout,           8'hA5);
    check("first_valid", W'(dout_valid), 8'h01);
    idle();
    check("first_pulse", W'(dout_valid), 8'h00);

    // Mixed modes back to back
    step(1'b0, '0, 2'b00, 1'b1, 8'h0F, 1'b0);
    step(1'b1, 8'h3C, 2'b00, 1'b0, '0, 1'b0);
    step(1'b1, 8'h3C, 2'b01, 1'b0, '0, 1'b0);
    check("b2b_bypass", dout, 8'h3C);
    step(1'b1, 8'h3C, 2'b10, 1'b0, '0, 1'b0);
    check("b2b_inv", dout, 8'hC3);
    check("b2b_v1",  W'(dout_valid), 8'h01);
    idle();
    check("b2b_mask", dout, 8'h33);
    check("b2b_v2",   W'(dout_valid), 8'h01);
    idle();
    check("b2b_end",  W'(dout_valid), 8'h00);

    // Mask load coincident with a masked compute
    step(1'b0, '0, 2'b00, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h00, 2'b10, 1'b0, '0, 1'b0);
    step(1'b1, 8'h00, 2'b10, 1'b1, 8'hF0, 1'b0);
    check("mask_old", dout, 8'hFF);
    idle();
    check("mask_new", dout, 8'hF0);
    check("mask_reg", mask_q, 8'hF0);

    // Toggle accumulation and clear-then-apply
    step(1'b0, '0, 2'b00, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h01, 2'b11, 1'b0, '0, 1'b0);
    step(1'b1, 8'h03, 2'b11, 1'b0, '0, 1'b0);
    check("tog_1", dout, 8'h01);
    step(1'b1, 8'h01, 2'b11, 1'b0, '0, 1'b0);
    check("tog_2", dout, 8'h02);
    step(1'b1, 8'h80, 2'b11, 1'b0, '0, 1'b0);
    check("tog_3", dout, 8'h03);
    step(1'b0, '0, 2'b00, 1'b0, '0, 1'b1);
    check("tog_clr_dout", dout,  8'h80);
    check("tog_clr_q",    tog_q, 8'h80);

    // Gaps: output holds, toggle state untouched
    step(1'b1, 8'h11, 2'b01, 1'b0, '0, 1'b0);
    idle();
    check("gap_dout", dout, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("gap_valid", W'(dout_valid), 8'h00);
      check("gap_hold",  dout,           8'hEE);
      check("gap_tog",   tog_q,          8'h80);
    end
    step(1'b1, 8'h22, 2'b00, 1'b0, '0, 1'b0);
    idle();
    check("gap_next", dout, 8'h22);

    // Asynchronous reset with a sample in stage 1
    step(1'b0, '0, 2'b00, 1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h77, 2'b01, 1'b0, '0, 1'b0);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout",  dout,           8'h00);
    check("arst_valid", W'(dout_valid), 8'h00);
    check("arst_mask",  mask_q,         8'hFF);
    check("arst_tog",   tog_q,          8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("arst_drop1", W'(dout_valid), 8'h00);
    idle();
    check("arst_drop2", W'(dout_valid), 8'h00);

    // Randomized traffic, with occasional mid-stream resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, W'($urandom), $urandom_range(0, 7) == 0);
      if (i % 200 == 199) async_reset_pulse();
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
